// File: rtl/pio_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pio_sampler_pkg
// Description : Shared encodings for the PIO sample sequencer: FSM states,
//               port-slave data address and overflow counter ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_sampler_pkg;

  // Sampling FSM: IDLE waits for a tick, WAIT covers the slave's read
  // latency, CAPT takes the sample.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
  localparam logic [15:0] OVF_MAX       = 16'hFFFF;

endpackage : pio_sampler_pkg
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               read straight from the storage registers, so it stays stable
//               until popped. A push at full is accepted if a pop happens in
//               the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array is not reset; only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign level     = count;

endmodule : sample_fifo
`default_nettype wire

// File: rtl/pio_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pio_sample_sequencer
// Description : Polls a parallel-input port slave at a programmable interval,
//               tags each sample with a free-running timestamp and streams
//               {timestamp, sample} words out of a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_sample_sequencer
  import pio_sampler_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TS_W       = 32,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_enable,
  input  logic [DIV_W-1:0]              cfg_period,
  input  logic                          cfg_change_only,
  output logic [1:0]                    pio_address,
  input  logic [DATA_W-1:0]             pio_readdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TS_W+DATA_W-1:0]        out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt,
  output logic                          busy
);

  logic [TS_W-1:0]   ts;
  logic [TS_W-1:0]   ts_hold;
  logic [DIV_W-1:0]  tick_cnt;
  logic              tick;
  state_t            state;
  logic [DATA_W-1:0] last_stored;
  logic              first;
  logic              enable_d;
  logic              capture;
  logic              want_push;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  assign tick = cfg_enable & (tick_cnt == cfg_period);

  // Free-running timestamp, independent of sampling enable.
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // Interval counter; a shrunk period that is already passed restarts at 0.
  always_ff @(posedge clk) begin
    if (reset || !cfg_enable)      tick_cnt <= '0;
    else if (tick_cnt >= cfg_period) tick_cnt <= '0;
    else                           tick_cnt <= tick_cnt + DIV_W'(1);
  end

  // Sampling FSM; ticks outside IDLE are dropped, disable aborts in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ts_hold <= '0;
    end else if (!cfg_enable) begin
      state   <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (tick) begin
          ts_hold <= ts;
          state   <= S_WAIT;
        end
        S_WAIT:  state <= S_CAPT;
        S_CAPT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign capture   = (state == S_CAPT) & cfg_enable;
  assign want_push = capture &
                     ~(cfg_change_only & ~first & (pio_readdata == last_stored));
  assign pop       = out_valid & out_ready;
  assign accept    = want_push & (~fifo_full | pop);

  // Change-detect history, first-sample flag and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_stored  <= '0;
      first        <= 1'b1;
      enable_d     <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      enable_d <= cfg_enable;
      if (cfg_enable && !enable_d) first <= 1'b1;
      else if (accept)             first <= 1'b0;
      if (accept) last_stored <= pio_readdata;
      if (want_push && !accept && overflow_cnt != OVF_MAX)
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  sample_fifo #(
    .WIDTH (TS_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data ({ts_hold, pio_readdata}),
    .pop       (pop),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid   = ~fifo_empty;
  assign pio_address = PIO_DATA_ADDR;
  assign busy        = (state != S_IDLE);

endmodule : pio_sample_sequencer
`default_nettype wire

// File: tb/tb_pio_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_sample_sequencer
// Description : Directed self-checking bench for pio_sample_sequencer with a
//               registered port-slave model and an output capture queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_enable;
  logic [15:0] cfg_period;
  logic        cfg_change_only;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;
  logic        busy;

  logic [31:0] ramp;
  logic [31:0] fixed_val;
  logic        use_fixed;
  logic [31:0] in_port;
  logic [63:0] q[$];

  int n_vec = 0;
  int n_err = 0;

  pio_sample_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_period      (cfg_period),
    .cfg_change_only (cfg_change_only),
    .pio_address     (pio_address),
    .pio_readdata    (pio_readdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .fifo_level      (fifo_level),
    .overflow_cnt    (overflow_cnt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Ramp shares reset and clock with the DUT timestamp, so ramp == timestamp.
  assign in_port = use_fixed ? fixed_val : ramp;

  // Port slave model: readdata registered one cycle after in_port.
  always @(posedge clk) begin
    if (reset) ramp <= 32'd0;
    else       ramp <= ramp + 32'd1;
    pio_readdata <= in_port;
  end

  // Record every word the consumer accepts.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
      q.push_back(out_data);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; cfg_enable = 1'b0; cfg_period = 16'd0; cfg_change_only = 1'b0;
    out_ready = 1'b0; use_fixed = 1'b0; fixed_val = 32'd0;
    step(3);
    reset = 1'b0;
    step(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0h expected 0", out_valid); end
    n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    n_vec++; if (pio_address !== 2'd0) begin n_err++; $display("FAIL reset_addr: got %0h expected 0", pio_address); end
  endtask

  // Sample taken in CAPT is readdata = in_port one cycle after the tick,
  // and in ramp mode that equals timestamp + 1.
  task automatic test_period9;
    logic [31:0] d;
    q.delete();
    cfg_period = 16'd9; cfg_change_only = 1'b0; use_fixed = 1'b0; out_ready = 1'b1;
    cfg_enable = 1'b1;
    step(50);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (q.size() !== 4) begin n_err++; $display("FAIL p9_count: got %0d expected 4", q.size()); end
    for (int i = 0; i < q.size(); i++) begin
      n_vec++;
      if (q[i][31:0] !== q[i][63:32] + 32'd1) begin
        n_err++; $display("FAIL p9_sample[%0d]: got %0h expected %0h", i, q[i][31:0], q[i][63:32] + 32'd1);
      end
    end
    for (int i = 1; i < q.size(); i++) begin
      d = q[i][63:32] - q[i-1][63:32];
      n_vec++; if (d !== 32'd10) begin n_err++; $display("FAIL p9_delta[%0d]: got %0d expected 10", i, d); end
    end
  endtask

  task automatic test_period0;
    logic [31:0] d;
    q.delete();
    cfg_period = 16'd0; cfg_enable = 1'b1;
    step(30);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (q.size() !== 10) begin n_err++; $display("FAIL p0_count: got %0d expected 10", q.size()); end
    for (int i = 1; i < q.size(); i++) begin
      d = q[i][63:32] - q[i-1][63:32];
      n_vec++; if (d !== 32'd3) begin n_err++; $display("FAIL p0_delta[%0d]: got %0d expected 3", i, d); end
    end
    for (int i = 0; i < q.size(); i++) begin
      n_vec++;
      if (q[i][31:0] !== q[i][63:32] + 32'd1) begin
        n_err++; $display("FAIL p0_sample[%0d]: got %0h expected %0h", i, q[i][31:0], q[i][63:32] + 32'd1);
      end
    end
    n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL p0_ovf: got %0d expected 0", overflow_cnt); end
  endtask

  task automatic test_change_only;
    q.delete();
    use_fixed = 1'b1; fixed_val = 32'hA5A5_0000; cfg_change_only = 1'b1; cfg_period = 16'd2;
    cfg_enable = 1'b1;
    step(30);
    n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL chg_count1: got %0d expected 1", q.size()); end
    n_vec++; if (q.size() > 0 && q[0][31:0] !== 32'hA5A5_0000) begin n_err++; $display("FAIL chg_data1: got %0h expected a5a50000", q[0][31:0]); end
    fixed_val = 32'h0000_0001;
    step(30);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (q.size() !== 2) begin n_err++; $display("FAIL chg_count2: got %0d expected 2", q.size()); end
    n_vec++; if (q.size() > 1 && q[1][31:0] !== 32'h1) begin n_err++; $display("FAIL chg_data2: got %0h expected 1", q[1][31:0]); end
  endtask

  // 20 captures at period 2 into a 16-deep FIFO with no consumer: 4 drops.
  task automatic test_overflow;
    logic [31:0] d;
    q.delete();
    out_ready = 1'b0; use_fixed = 1'b0; cfg_change_only = 1'b0; cfg_period = 16'd2;
    cfg_enable = 1'b1;
    step(62);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
    n_vec++; if (overflow_cnt !== 16'd4) begin n_err++; $display("FAIL ovf_cnt: got %0d expected 4", overflow_cnt); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid: got %0h expected 1", out_valid); end
    n_vec++; if (q.size() !== 0) begin n_err++; $display("FAIL ovf_nopop: got %0d expected 0", q.size()); end
    // Capture lands in cycle E+4; consumer pops in exactly that cycle.
    cfg_enable = 1'b1;
    step(4);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0; cfg_enable = 1'b0;
    n_vec++; if (fifo_level !== 5'd16) begin n_err++; $display("FAIL full_pp_level: got %0d expected 16", fifo_level); end
    n_vec++; if (overflow_cnt !== 16'd4) begin n_err++; $display("FAIL full_pp_ovf: got %0d expected 4", overflow_cnt); end
    n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL full_pp_pop: got %0d expected 1", q.size()); end
    out_ready = 1'b1;
    step(20);
    n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
    n_vec++; if (q.size() !== 17) begin n_err++; $display("FAIL drain_count: got %0d expected 17", q.size()); end
    if (q.size() == 17) begin
      d = q[15][63:32] - q[0][63:32];
      n_vec++; if (d !== 32'd45) begin n_err++; $display("FAIL drain_span: got %0d expected 45", d); end
      n_vec++;
      if (q[16][31:0] !== q[16][63:32] + 32'd1) begin
        n_err++; $display("FAIL drain_last: got %0h expected %0h", q[16][31:0], q[16][63:32] + 32'd1);
      end
    end
  endtask

  task automatic test_disable_in_wait;
    q.delete();
    use_fixed = 1'b1; fixed_val = 32'h0000_1234; cfg_change_only = 1'b1; cfg_period = 16'd2;
    out_ready = 1'b1;
    cfg_enable = 1'b1;
    step(12);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL dis_first: got %0d expected 1", q.size()); end
    // Re-enable, then drop enable while the FSM sits in WAIT.
    cfg_enable = 1'b1;
    step(3);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL dis_inwait: got %0h expected 1", busy); end
    cfg_enable = 1'b0;
    step(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_busy: got %0h expected 0", busy); end
    step(10);
    n_vec++; if (q.size() !== 1) begin n_err++; $display("FAIL dis_nopush: got %0d expected 1", q.size()); end
    cfg_enable = 1'b1;
    step(12);
    cfg_enable = 1'b0;
    step(5);
    n_vec++; if (q.size() !== 2) begin n_err++; $display("FAIL reen_count: got %0d expected 2", q.size()); end
    n_vec++; if (q.size() > 1 && q[1][31:0] !== 32'h1234) begin n_err++; $display("FAIL reen_data: got %0h expected 1234", q[1][31:0]); end
  endtask

  task automatic test_reset_flush;
    bit found;
    q.delete();
    out_ready = 1'b0; use_fixed = 1'b0; cfg_change_only = 1'b0; cfg_period = 16'd2;
    cfg_enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (fifo_level == 5'd5) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL flush_fill: got level %0d expected 5", fifo_level); end
    reset = 1'b1;
    step(1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0h expected 0", out_valid); end
    n_vec++; if (fifo_level !== 5'd0) begin n_err++; $display("FAIL flush_level: got %0d expected 0", fifo_level); end
    n_vec++; if (overflow_cnt !== 16'd0) begin n_err++; $display("FAIL flush_ovf: got %0d expected 0", overflow_cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %0h expected 0", busy); end
    reset = 1'b0; cfg_enable = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_period9();
    test_period0();
    test_change_only();
    test_overflow();
    test_disable_in_wait();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pio_sample_sequencer
`default_nettype wire
